// File: rtl/octave_pkg.sv
// Shared types and defaults for the octave selector.
// Build option: OCTAVE_CTRL_AUTOREPEAT_EN enables auto-repeat while a button is held.
package octave_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCKOUT = 2'd1,
      HOLD    = 2'd2
   } octState_e;

   localparam int DEF_NUM_OCT    = 4;
   localparam int DEF_RESET_OCT  = 0;
   localparam int DEF_WRAP       = 0;
   localparam int DEF_LOCK_CYC   = 4;
   localparam int DEF_REPEAT_DLY = 10;
   localparam int DEF_REPEAT_PER = 5;

   // One step toward the requested direction; at the ends either wrap around
   // or stay put. Comparing against numOct-1 keeps the result below numOct
   // even when numOct is not a power of two.
   function automatic int stepOct(input int cur, input logic up,
                                  input int numOct, input logic wrap);
      int res;
      res = cur;
      if (up) begin
         if (cur >= numOct - 1) begin
            res = wrap ? 0 : numOct - 1;
         end else begin
            res = cur + 1;
         end
      end else begin
         if (cur <= 0) begin
            res = wrap ? numOct - 1 : 0;
         end else begin
            res = cur - 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rise_edge.sv
// Per-button rising-edge detector. The previous-level register comes out of
// reset at 1 so a button already held through reset does not count as a press.
module rise_edge (
   input  logic clk,
   input  logic nrst,
   input  logic level_i,
   output logic rise_o
);

   logic prevLevel_q;

   // Remember last cycle's level so a 0->1 transition can be spotted.
   always_ff @(posedge clk) begin
      if (nrst) begin
         prevLevel_q <= 1'b1;
      end else begin
         prevLevel_q <= level_i;
      end
   end

   assign rise_o = level_i & ~prevLevel_q;

endmodule

// File: rtl/octave_ctrl.sv
// Octave up/down selector with press lockout and optional auto-repeat.
// Build option: OCTAVE_CTRL_AUTOREPEAT_EN -- when defined, a button held in
// HOLD steps again after REPEAT_DLY cycles and then every REPEAT_PER cycles.
module octave_ctrl
   import octave_pkg::*;
#(
   parameter int NUM_OCT    = DEF_NUM_OCT,
   parameter int RESET_OCT  = DEF_RESET_OCT,
   parameter int WRAP       = DEF_WRAP,
   parameter int LOCK_CYC   = DEF_LOCK_CYC,
   parameter int REPEAT_DLY = DEF_REPEAT_DLY,
   parameter int REPEAT_PER = DEF_REPEAT_PER,
   localparam int OCT_W     = (NUM_OCT > 1) ? $clog2(NUM_OCT) : 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             oct_up,
   input  logic             oct_down,
   output logic [OCT_W-1:0] oct_sel,
   output logic             at_min,
   output logic             at_max,
   output logic             oct_changed
);

   localparam int LCW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
   localparam logic [OCT_W-1:0] MAX_OCT   = OCT_W'(NUM_OCT - 1);
   localparam logic [OCT_W-1:0] RESET_VAL = OCT_W'(RESET_OCT);
   localparam logic [LCW-1:0]   LOCK_LOAD = LCW'(LOCK_CYC - 1);

   logic riseUp;
   logic riseDown;

   octState_e        state_q,   state_d;
   logic [LCW-1:0]   lockCnt_q, lockCnt_d;
   logic             dirUp_q,   dirUp_d;
   logic [OCT_W-1:0] octSel_q,  octSel_d;
   logic             atMin_q,   atMin_d;
   logic             atMax_q,   atMax_d;
   logic             changed_q, changed_d;

   logic stepReq;
   logic stepUp;
   logic heldLevel;

`ifdef OCTAVE_CTRL_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam logic [RCW-1:0] DLY_LOAD = RCW'(REPEAT_DLY - 1);
   localparam logic [RCW-1:0] PER_LOAD = RCW'(REPEAT_PER - 1);

   logic [RCW-1:0] repCnt_q, repCnt_d;
`else
   logic unusedRepeatCfg;
   assign unusedRepeatCfg = ^{REPEAT_DLY, REPEAT_PER};
`endif

   rise_edge u_riseUp (
      .clk     (clk),
      .nrst    (nrst),
      .level_i (oct_up),
      .rise_o  (riseUp)
   );

   rise_edge u_riseDown (
      .clk     (clk),
      .nrst    (nrst),
      .level_i (oct_down),
      .rise_o  (riseDown)
   );

   assign heldLevel = dirUp_q ? oct_up : oct_down;

   // Next-state logic: decides when a step is taken and how the lockout and
   // repeat counters advance.
   always_comb begin
      state_d   = state_q;
      lockCnt_d = lockCnt_q;
      dirUp_d   = dirUp_q;
      stepReq   = 1'b0;
      stepUp    = dirUp_q;
`ifdef OCTAVE_CTRL_AUTOREPEAT_EN
      repCnt_d  = repCnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (riseUp ^ riseDown) begin
               stepReq   = 1'b1;
               stepUp    = riseUp;
               dirUp_d   = riseUp;
               lockCnt_d = LOCK_LOAD;
               state_d   = LOCKOUT;
`ifdef OCTAVE_CTRL_AUTOREPEAT_EN
               repCnt_d  = DLY_LOAD;
`endif
            end
         end
         LOCKOUT: begin
`ifdef OCTAVE_CTRL_AUTOREPEAT_EN
            if (repCnt_q != '0) begin
               repCnt_d = repCnt_q - 1'b1;
            end
`endif
            if (lockCnt_q == '0) begin
               state_d = heldLevel ? HOLD : IDLE;
            end else begin
               lockCnt_d = lockCnt_q - 1'b1;
            end
         end
         HOLD: begin
            if (!heldLevel) begin
               state_d = IDLE;
`ifdef OCTAVE_CTRL_AUTOREPEAT_EN
               repCnt_d = '0;
            end else if (repCnt_q == '0) begin
               stepReq  = 1'b1;
               stepUp   = dirUp_q;
               repCnt_d = PER_LOAD;
            end else begin
               repCnt_d = repCnt_q - 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath: apply a requested step and derive the registered flags from
   // the new value so they line up with oct_sel.
   always_comb begin
      octSel_d = octSel_q;
      if (stepReq) begin
         octSel_d = OCT_W'(stepOct(int'(octSel_q), stepUp, NUM_OCT, WRAP != 0));
      end
      changed_d = (octSel_d != octSel_q);
      atMin_d   = (octSel_d == '0);
      atMax_d   = (octSel_d == MAX_OCT);
   end

   // State and output registers; reset overrides everything in any state.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q   <= IDLE;
         lockCnt_q <= '0;
         dirUp_q   <= 1'b0;
         octSel_q  <= RESET_VAL;
         atMin_q   <= (RESET_VAL == '0);
         atMax_q   <= (RESET_VAL == MAX_OCT);
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lockCnt_q <= lockCnt_d;
         dirUp_q   <= dirUp_d;
         octSel_q  <= octSel_d;
         atMin_q   <= atMin_d;
         atMax_q   <= atMax_d;
         changed_q <= changed_d;
      end
   end

`ifdef OCTAVE_CTRL_AUTOREPEAT_EN
   // Repeat timer: counts cycles since the last step while a button is held.
   always_ff @(posedge clk) begin
      if (nrst) begin
         repCnt_q <= '0;
      end else begin
         repCnt_q <= repCnt_d;
      end
   end
`endif

   assign oct_sel     = octSel_q;
   assign at_min      = atMin_q;
   assign at_max      = atMax_q;
   assign oct_changed = changed_q;

endmodule

// File: doc/octave_ctrl.md
OCTAVE_CTRL -- requirements
Module: octave_ctrl

Interface
REQ-001 Parameter NUM_OCT, 4, number of selectable octaves (2..16).
REQ-002 Parameter RESET_OCT, 0, octave index loaded on reset (< NUM_OCT).
REQ-003 Parameter WRAP, 0, 1 = wrap at ends, 0 = saturate at ends.
REQ-004 Parameter LOCK_CYC, 4, lockout cycles after an accepted step (>= 1).
REQ-005 Parameter REPEAT_DLY, 10, cycles a button is held before auto-repeat starts.
REQ-006 Parameter REPEAT_PER, 5, auto-repeat step period in cycles.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 nrst  in  1  reset; synchronous, active-high (asserted = 1), sampled on the rising edge of clk.
REQ-009 oct_up  in  1  octave-up button level, already synchronised to clk.
REQ-010 oct_down  in  1  octave-down button level, already synchronised to clk.
REQ-011 oct_sel  out  OCT_W = $clog2(NUM_OCT)  current octave index, registered.
REQ-012 at_min / at_max  out  1 each  oct_sel == 0 / oct_sel == NUM_OCT-1, registered.
REQ-013 oct_changed  out  1  single-cycle pulse, high in the first cycle oct_sel shows a new value.

Function
REQ-014 Rising edge = current level AND NOT previous registered level, per button.
REQ-015 FSM states: IDLE, LOCKOUT, HOLD.
REQ-016 IDLE: exactly one rising edge -> step oct_sel by one toward the button's direction, load lockout counter with LOCK_CYC-1, go LOCKOUT.
REQ-017 Up and down edges in the same cycle -> no step, remain IDLE.
REQ-018 Step at boundary: WRAP=0 -> oct_sel unchanged, oct_changed stays 0, FSM still enters LOCKOUT; WRAP=1 -> NUM_OCT-1 wraps to 0 and 0 wraps to NUM_OCT-1.
REQ-019 Latency: oct_sel, at_min, at_max, oct_changed update on the same clock edge that samples the rising edge (visible one cycle after input rises).
REQ-020 LOCKOUT: all edges ignored; counter decrements each cycle; at 0 -> HOLD if the stepping button is still high, else IDLE.
REQ-021 HOLD: no steps unless auto-repeat is compiled in; release of the held button -> IDLE next cycle; edges on the other button ignored.
REQ-022 oct_changed is 0 in every cycle where oct_sel does not change value.
REQ-023 Arithmetic in OCT_W bits; oct_sel never reaches a value >= NUM_OCT, including non-power-of-two NUM_OCT.

Reset
REQ-024 nrst=1: oct_sel=RESET_OCT, at_min/at_max reflect RESET_OCT, oct_changed=0, state=IDLE, counters=0.
REQ-025 Previous-level registers reset to 1, so a button held through reset produces no step.
REQ-026 Reset asserted in any state, including mid-lockout or mid-repeat, takes effect at the next rising edge and overrides all inputs.

Configuration
REQ-027 Macro OCTAVE_CTRL_AUTOREPEAT_EN controls auto-repeat.
REQ-028 Defined: in HOLD, a button held continuously for REPEAT_DLY cycles since its accepted step steps again, then every REPEAT_PER cycles while held, with REQ-018 boundary rules; release -> IDLE.
REQ-029 Undefined: HOLD never steps, REPEAT_DLY/REPEAT_PER are unused, no repeat counter is instantiated.

Structure
REQ-030 Package octave_pkg holds the state enum (IDLE, LOCKOUT, HOLD) and default parameter constants.
REQ-031 One sub-module, rise_edge, implements the per-button edge detector; it is instantiated twice.

Verification
REQ-032 Reset: nrst=1 for 2 cycles -> oct_sel=0, at_min=1, at_max=0, oct_changed=0.
REQ-033 NUM_OCT=4, WRAP=0: four up pulses spaced 10 cycles apart -> oct_sel 1,2,3,3; oct_changed pulses three times; at_max=1 after the third; WRAP=1 -> fourth pulse gives 0.
REQ-034 LOCK_CYC=4: up edges 2 cycles apart -> single step; repeated 6 cycles apart -> two steps.
REQ-035 oct_up and oct_down rise in the same cycle at oct_sel=1 -> oct_sel stays 1, oct_changed=0.
REQ-036 AUTOREPEAT_EN, NUM_OCT=8, REPEAT_DLY=10, REPEAT_PER=5: oct_up held 30 cycles from oct_sel=0 -> steps at cycles 1, 11, 16, 21, 26 -> oct_sel=5; without macro -> oct_sel=1.
REQ-037 nrst=1 during LOCKOUT at oct_sel=2 -> oct_sel=RESET_OCT, state IDLE; held button does not step after reset release.
